// File: rtl/line_buffer.sv
// 3x3 sliding-window generator. Raster pixels stream in, and each interior pixel
// completes one window. The window is held in a one-deep valid/ready output register.
module line_buffer #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [7:0]  pix_i,
    input  logic        pix_valid_i,
    output logic        pix_ready_o,
    output logic [71:0] data_o,
    output logic        data_valid_o,
    input  logic        data_ready_i,
    output logic [9:0]  win_col_o,
    output logic [9:0]  win_row_o,
    output logic        frame_done_o
);
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t     state, state_nxt;
    logic [9:0] col, row;
    logic [7:0] lb_new [IMG_W];
    logic [7:0] lb_old [IMG_W];
    logic [7:0] t1, t2, m1, m2, b1, b2;
    logic       acc, win_ld, last_pix;

    assign pix_ready_o = (state == LOAD) && (!data_valid_o || data_ready_i);
    assign acc         = pix_valid_i && pix_ready_o;
    assign win_ld      = acc && (row >= 10'd2) && (col >= 10'd2);
    assign last_pix    = acc && (row == 10'(IMG_H - 1)) && (col == 10'(IMG_W - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        frame_done_o = 1'b0;
        case (state)
            IDLE:  if (start_i) state_nxt = LOAD;
            LOAD:  if (last_pix) state_nxt = DRAIN;
            DRAIN: if (!data_valid_o || data_ready_i) state_nxt = DONE;
            DONE: begin
                frame_done_o = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (state == IDLE && start_i) begin
            col <= '0;
            row <= '0;
        end else if (acc) begin
            if (col == 10'(IMG_W - 1)) begin
                col <= '0;
                row <= row + 10'd1;
            end else begin
                col <= col + 10'd1;
            end
        end
    end

    // Tail of each store is the same column one and two rows up; the column
    // taps lag by one and two pixels, so they may hold a previous row's pixels
    // at columns 0/1. Those positions never emit a window.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb_new[0] <= pix_i;
            lb_old[0] <= lb_new[IMG_W-1];
            for (int i = 1; i < IMG_W; i++) begin
                lb_new[i] <= lb_new[i-1];
                lb_old[i] <= lb_old[i-1];
            end
            t2 <= t1; t1 <= lb_old[IMG_W-1];
            m2 <= m1; m1 <= lb_new[IMG_W-1];
            b2 <= b1; b1 <= pix_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_o       <= '0;
            data_valid_o <= 1'b0;
            win_col_o    <= '0;
            win_row_o    <= '0;
        end else if (win_ld) begin
            data_o       <= {t2, t1, lb_old[IMG_W-1], m2, m1, lb_new[IMG_W-1], b2, b1, pix_i};
            data_valid_o <= 1'b1;
            win_col_o    <= col - 10'd2;
            win_row_o    <= row - 10'd2;
        end else if (data_ready_i) begin
            data_valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_line_buffer.sv
// Directed bench for line_buffer on a 4x4 image with pixel value 4r+c.
module tb_line_buffer;
    logic        clk = 1'b0;
    logic        rst, start_i, pix_valid_i, pix_ready_o, data_valid_o, data_ready_i, frame_done_o;
    logic [7:0]  pix_i;
    logic [71:0] data_o;
    logic [9:0]  win_col_o, win_row_o;

    int passed = 0;
    int total  = 0;
    int pidx, widx, n_done;

    logic [71:0] exp_w [4];
    logic [9:0]  exp_r [4];
    logic [9:0]  exp_c [4];

    always #5 clk = ~clk;

    line_buffer #(.IMG_W(4), .IMG_H(4)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .pix_i(pix_i),
        .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
        .data_o(data_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
        .win_col_o(win_col_o), .win_row_o(win_row_o), .frame_done_o(frame_done_o)
    );

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 72'(data_valid_o), 72'd0);
        chk({tag, "_ready"}, 72'(pix_ready_o), 72'd0);
        chk({tag, "_done"},  72'(frame_done_o), 72'd0);
        chk({tag, "_data"},  data_o, 72'd0);
        chk({tag, "_col"},   72'(win_col_o), 72'd0);
        chk({tag, "_row"},   72'(win_row_o), 72'd0);
    endtask

    // One frame: optional random valid gaps, an optional 5-cycle downstream stall,
    // optional stray start pulses in LOAD and DONE, optional abort after abort_at pixels.
    task automatic run_frame(input bit gaps, input bit stall, input bit stray, input int abort_at);
        bit acc, stalled, done_seen, finished;
        int cyc;
        pidx = 0; widx = 0; n_done = 0;
        stalled = 0; done_seen = 0; finished = 0; cyc = 0;
        data_ready_i = 1'b1;
        start_i = 1'b1; pix_valid_i = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;
        while (!finished && cyc < 300) begin
            cyc++;
            if (abort_at >= 0 && pidx == abort_at) return;
            if (stall && !stalled && data_valid_o) begin
                stalled = 1;
                data_ready_i = 1'b0; pix_valid_i = 1'b1; pix_i = 8'(pidx);
                repeat (5) begin
                    @(posedge clk); #1;
                    chk("stall_data",  data_o, exp_w[0]);
                    chk("stall_ready", 72'(pix_ready_o), 72'd0);
                end
                data_ready_i = 1'b1;
            end
            if (done_seen) finished = 1;
            start_i     = stray && ((pidx == 5) || frame_done_o);
            pix_valid_i = (pidx < 16) && !(gaps && $urandom_range(0, 2) == 0);
            pix_i       = 8'(pidx);
            #1;
            acc = pix_valid_i && pix_ready_o;
            if (data_valid_o && data_ready_i) begin
                if (widx < 4) begin
                    chk("win_data", data_o, exp_w[widx]);
                    chk("win_row",  72'(win_row_o), 72'(exp_r[widx]));
                    chk("win_col",  72'(win_col_o), 72'(exp_c[widx]));
                end else begin
                    chk("win_extra", 72'(widx), 72'd3);
                end
                widx++;
            end
            @(posedge clk); #1;
            if (acc) begin
                if (pidx == 10) begin
                    chk("lat_valid", 72'(data_valid_o), 72'd1);
                    chk("lat_data",  data_o, exp_w[0]);
                end
                if (pidx == 12 || pidx == 13) chk("edge_novalid", 72'(data_valid_o), 72'd0);
                if (pidx == 14) begin
                    chk("edge_row", 72'(win_row_o), 72'd1);
                    chk("edge_col", 72'(win_col_o), 72'd0);
                end
                pidx++;
            end
            if (frame_done_o) begin
                n_done++;
                done_seen = 1;
            end
        end
        start_i = 1'b0; pix_valid_i = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (frame_done_o) n_done++;
            chk("idle_ready", 72'(pix_ready_o), 72'd0);
        end
        pix_valid_i = 1'b0;
        chk("frame_windows", 72'(widx), 72'd4);
        chk("frame_done_cnt", 72'(n_done), 72'd1);
    endtask

    initial begin
        exp_w[0] = {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8,  8'd9,  8'd10};
        exp_w[1] = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9,  8'd10, 8'd11};
        exp_w[2] = {8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd14};
        exp_w[3] = {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
        exp_r[0] = 10'd0; exp_c[0] = 10'd0;
        exp_r[1] = 10'd0; exp_c[1] = 10'd1;
        exp_r[2] = 10'd1; exp_c[2] = 10'd0;
        exp_r[3] = 10'd1; exp_c[3] = 10'd1;

        rst = 1'b1; start_i = 1'b0; pix_valid_i = 1'b0; pix_i = 8'd0; data_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;

        run_frame(1'b0, 1'b0, 1'b0, -1);   // back-to-back
        run_frame(1'b0, 1'b1, 1'b0, -1);   // downstream stall
        run_frame(1'b1, 1'b0, 1'b0, -1);   // random valid gaps

        run_frame(1'b0, 1'b0, 1'b0, 7);    // abort mid-frame with reset
        chk("abort_pixels", 72'(pidx), 72'd7);
        pix_valid_i = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("midreset");
        rst = 1'b0;
        run_frame(1'b0, 1'b0, 1'b0, -1);

        run_frame(1'b0, 1'b0, 1'b1, -1);   // stray start pulses

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/line_buffer.md
LINE_BUFFER -- requirements
Module: line_buffer

Interface
REQ-001 The module SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter IMG_W, default 32: image width in pixels, legal range 3..1023.
REQ-003 Parameter IMG_H, default 32: image height in pixels, legal range 3..1023.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start_i  input  1  controller pulse that starts one frame.
REQ-007 pix_i  input  8  raster-order pixel, row-major, column 0 first.
REQ-008 pix_valid_i  input  1  pix_i is valid.
REQ-009 pix_ready_o  output  1  block accepts pix_i this cycle.
REQ-010 data_o  output  72  3x3 window to preprocess stage.
REQ-011 data_valid_o  output  1  data_o holds a valid window.
REQ-012 data_ready_i  input  1  downstream consumes data_o this cycle.
REQ-013 win_col_o  output  10  column of the window's top-left pixel.
REQ-014 win_row_o  output  10  row of the window's top-left pixel.
REQ-015 frame_done_o  output  1  one-cycle pulse, frame fully emitted.

Function
REQ-016 A pixel SHALL be accepted only on a cycle with pix_valid_i && pix_ready_o.
REQ-017 pix_ready_o SHALL be 1 only in LOAD and only when !data_valid_o || data_ready_i.
REQ-018 States SHALL be IDLE, LOAD, DRAIN, DONE.
REQ-019 IDLE: start_i=1 -> LOAD, with col/row counters cleared the same edge; otherwise stay.
REQ-020 LOAD: acceptance of pixel (IMG_H-1, IMG_W-1) -> DRAIN.
REQ-021 DRAIN: when data_valid_o=0, or data_valid_o && data_ready_i -> DONE.
REQ-022 DONE: frame_done_o=1 for exactly that cycle, then -> IDLE.
REQ-023 start_i outside IDLE SHALL be ignored.
REQ-024 Column counter SHALL increment per accepted pixel and wrap IMG_W-1 -> 0, incrementing the row counter on wrap.
REQ-025 Two line stores of IMG_W pixels SHALL hold the previous two rows; each accepted pixel shifts into the newest store and the displaced pixel into the older store.
REQ-026 Acceptance of pixel (r,c) with r>=2 and c>=2 SHALL complete window rows r-2..r, columns c-2..c.
REQ-027 Columns 0 and 1 of any row, and all of rows 0 and 1, SHALL produce no window: no wrap across line ends.
REQ-028 Packing: data_o[71:64]=(r-2,c-2), [63:56]=(r-2,c-1), [55:48]=(r-2,c), [47:40]=(r-1,c-2) ... [7:0]=(r,c), row-major.
REQ-029 Latency: data_o, win_row_o=r-2, win_col_o=c-2 and data_valid_o=1 SHALL be registered on the edge that accepts pixel (r,c).
REQ-030 data_valid_o SHALL clear after a data_ready_i handshake unless a new window is loaded the same edge; a simultaneous consume and load SHALL keep it at 1 with new data.
REQ-031 While data_valid_o=1 and data_ready_i=0, data_o, win_col_o and win_row_o SHALL hold stable and no pixel SHALL be accepted.
REQ-032 Windows per frame SHALL be exactly (IMG_W-2)*(IMG_H-2), in raster order.

Reset
REQ-033 On rst=1 at a rising edge: state=IDLE; data_o=0, data_valid_o=0, pix_ready_o=0, win_col_o=0, win_row_o=0, frame_done_o=0, counters=0.
REQ-034 Reset SHALL take priority over every other input, including mid-frame; line-store contents need not be cleared.

Verification (IMG_W=4, IMG_H=4, pixel value = 4r+c)
REQ-035 Reset, start_i, 16 pixels back-to-back, data_ready_i=1 -> 4 windows; first, registered on acceptance of pixel 10: data_o={0,1,2,4,5,6,8,9,10}, row 0, col 0; last {5,6,7,9,10,11,13,14,15}, row 1, col 1; frame_done_o pulses once.
REQ-036 data_ready_i=0 for 5 cycles while data_valid_o=1 -> data_o stable, pix_ready_o=0, window sequence unchanged afterwards.
REQ-037 Random pix_valid_i gaps -> window sequence identical to REQ-035.
REQ-038 rst asserted after 7 pixels -> reset values next cycle; a new start_i and full frame reproduce REQ-035.
REQ-039 start_i pulsed during LOAD and DONE -> ignored; exactly one frame_done_o pulse per frame.
REQ-040 Pixels (3,0) and (3,1) accepted -> data_valid_o stays 0; pixel (3,2) -> window row 1, col 0.
